// File: rtl/com_fw_dut_arbiter.sv
// Round-robin arbiter handing the shared DUT pin interface to one of four firmware IPs,
// with guard intervals around each hand-over. Optional watchdog: COM_FW_DUT_ARBITER_TIMEOUT_EN.
module com_fw_dut_arbiter #(
    parameter int GUARD_CYCLES     = 8,
    parameter int CNT_WIDTH        = 16,
    parameter int MAX_GRANT_CYCLES = 1000000
) (
    input  logic                 iob_clk,
    input  logic                 reset,
    input  logic [3:0]           fw_req,
    input  logic                 sw_lock,
    input  logic                 timeout_clr,
    output logic [3:0]           fw_grant,
    output logic [3:0]           fw_dev_id_enable,
    output logic                 arb_busy,
    output logic [CNT_WIDTH-1:0] grant_cnt,
    output logic [3:0]           timeout_flag
);

    typedef enum logic [1:0] {IDLE, GUARD_IN, GRANT, GUARD_OUT} state_t;

    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic [31:0] MAX_LIM    = 32'(MAX_GRANT_CYCLES);
    // firmware_id_1..firmware_id_4 from cms_pix28_package (one-hot selector codes)
    localparam logic [3:0]  FIRMWARE_ID [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    state_t               state_q, state_d;
    logic [1:0]           w_q, w_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [7:0]           guard_q, guard_d;
    logic [3:0]           fw_grant_q, fw_grant_d;
    logic [3:0]           fw_id_q, fw_id_d;
    logic                 arb_busy_q, arb_busy_d;
    logic [CNT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
    logic [3:0]           timeout_flag_q, timeout_flag_d;
    logic [3:0]           rearm_q, rearm_d;

    logic [3:0] eligible;
    logic [3:0] elig_rot;
    logic [1:0] pick_off;
    logic       pick_any;
    logic [1:0] winner;
    logic       force_rel;
    logic [3:0] release_set;
    logic       hold;

    assign eligible = fw_req & ~rearm_q;

    // Eligibility rotated so that bit 0 is the index rr_ptr currently points at.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        logic [1:0] rot_idx;
        assign rot_idx      = rr_ptr_q + 2'(gi);
        assign elig_rot[gi] = eligible[rot_idx];
    end

    always_comb begin
        pick_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (elig_rot[k]) pick_off = 2'(k);
        end
        pick_any = |elig_rot;
        winner   = rr_ptr_q + pick_off;
    end

`ifdef COM_FW_DUT_ARBITER_TIMEOUT_EN
    logic [31:0] age_q, age_d;

    assign force_rel = (state_q == GRANT) && (MAX_LIM != 32'd0) && (age_q == MAX_LIM);
    assign age_d     = (state_q == GRANT) ? age_q + 32'd1 : 32'd0;
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        rr_ptr_d    = rr_ptr_q;
        guard_d     = guard_q;
        release_set = 4'b0;
        case (state_q)
            IDLE: begin
                if (!sw_lock && pick_any) begin
                    w_d     = winner;
                    guard_d = GUARD_LOAD;
                    state_d = GUARD_IN;
                end
            end
            GUARD_IN: begin
                if (!fw_req[w_q])          state_d = IDLE;
                else if (guard_q == 8'd0)  state_d = GRANT;
                else                       guard_d = guard_q - 8'd1;
            end
            GRANT: begin
                if (!fw_req[w_q] || force_rel) begin
                    rr_ptr_d = w_q + 2'd1;
                    guard_d  = GUARD_LOAD;
                    state_d  = GUARD_OUT;
                    if (force_rel) release_set = 4'b0001 << w_q;
                end
            end
            GUARD_OUT: begin
                if (guard_q == 8'd0) state_d = IDLE;
                else                 guard_d = guard_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs lag the state by one edge, but drop on the same edge a release is sampled.
        hold        = (state_q == GRANT) && (state_d == GRANT);
        fw_grant_d  = hold ? (4'b0001 << w_q) : 4'b0;
        fw_id_d     = hold ? FIRMWARE_ID[w_q] : 4'b0;
        arb_busy_d  = (state_q != IDLE);
        grant_cnt_d = grant_cnt_q;
        if (hold && (fw_grant_q == 4'b0) && (grant_cnt_q != {CNT_WIDTH{1'b1}}))
            grant_cnt_d = grant_cnt_q + 1'b1;

`ifdef COM_FW_DUT_ARBITER_TIMEOUT_EN
        timeout_flag_d = (timeout_clr ? 4'b0 : timeout_flag_q) | release_set;
        rearm_d        = (rearm_q & fw_req) | release_set;
`else
        timeout_flag_d = 4'b0;
        rearm_d        = 4'b0;
`endif
    end

`ifndef COM_FW_DUT_ARBITER_TIMEOUT_EN
    logic unused_cfg;
    assign unused_cfg = ^{timeout_clr, MAX_LIM, release_set};
`endif

    always_ff @(posedge iob_clk) begin
        if (reset) begin
            state_q        <= IDLE;
            w_q            <= 2'd0;
            rr_ptr_q       <= 2'd0;
            guard_q        <= 8'd0;
            fw_grant_q     <= 4'b0;
            fw_id_q        <= 4'b0;
            arb_busy_q     <= 1'b0;
            grant_cnt_q    <= '0;
            timeout_flag_q <= 4'b0;
            rearm_q        <= 4'b0;
`ifdef COM_FW_DUT_ARBITER_TIMEOUT_EN
            age_q          <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            w_q            <= w_d;
            rr_ptr_q       <= rr_ptr_d;
            guard_q        <= guard_d;
            fw_grant_q     <= fw_grant_d;
            fw_id_q        <= fw_id_d;
            arb_busy_q     <= arb_busy_d;
            grant_cnt_q    <= grant_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            rearm_q        <= rearm_d;
`ifdef COM_FW_DUT_ARBITER_TIMEOUT_EN
            age_q          <= age_d;
`endif
        end
    end

    assign fw_grant         = fw_grant_q;
    assign fw_dev_id_enable = fw_id_q;
    assign arb_busy         = arb_busy_q;
    assign grant_cnt        = grant_cnt_q;
    assign timeout_flag     = timeout_flag_q;

endmodule

// File: tb/tb_com_fw_dut_arbiter.sv
// Directed bench for com_fw_dut_arbiter: expected grants are queued as requests are driven
// and checked by a monitor when each grant rises.
module tb_com_fw_dut_arbiter;

    logic        iob_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  fw_req = 4'b0;
    logic        sw_lock = 1'b0;
    logic        timeout_clr = 1'b0;
    logic [3:0]  fw_grant;
    logic [3:0]  fw_dev_id_enable;
    logic        arb_busy;
    logic [15:0] grant_cnt;
    logic [3:0]  timeout_flag;

    com_fw_dut_arbiter #(
        .GUARD_CYCLES(8),
        .CNT_WIDTH(16),
        .MAX_GRANT_CYCLES(20)
    ) dut (
        .iob_clk(iob_clk),
        .reset(reset),
        .fw_req(fw_req),
        .sw_lock(sw_lock),
        .timeout_clr(timeout_clr),
        .fw_grant(fw_grant),
        .fw_dev_id_enable(fw_dev_id_enable),
        .arb_busy(arb_busy),
        .grant_cnt(grant_cnt),
        .timeout_flag(timeout_flag)
    );

    always #5 iob_clk = ~iob_clk;

    typedef struct {
        logic [3:0]  grant;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   last_fall = -1;
    logic [3:0] prev_grant = 4'b0;

    always @(posedge iob_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge iob_clk);
    endtask

    task automatic expect_grant(input logic [3:0] g, input int at_cyc);
        exp_t e;
        exp_cnt++;
        e.grant = g;
        e.cnt   = 16'(exp_cnt);
        e.cyc   = at_cyc;
        sb.push_back(e);
    endtask

    task automatic wait_grant(input string tag);
        int i = 0;
        while (fw_grant == 4'b0 && i < 300) begin
            @(negedge iob_clk);
            i++;
        end
        check({tag, "_grant_seen"}, 32'(fw_grant != 4'b0), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (arb_busy !== 1'b0 && i < 300) begin
            @(negedge iob_clk);
            i++;
        end
        check({tag, "_idle"}, 32'(arb_busy), 32'd0);
    endtask

    // Grant monitor: invariants every cycle, scoreboard pop on every rising grant.
    always @(negedge iob_clk) begin
        check("onehot", 32'($onehot0(fw_grant)), 32'd1);
        check("id_match", 32'(fw_dev_id_enable), 32'(fw_grant));
        if (fw_grant != 4'b0 && prev_grant == 4'b0) begin
            $display("grant %b id %b cnt %0d at cyc %0d", fw_grant, fw_dev_id_enable, grant_cnt, cyc);
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(fw_grant), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("grant", 32'(fw_grant), 32'(mon_e.grant));
                check("grant_cnt", 32'(grant_cnt), 32'(mon_e.cnt));
                if (mon_e.cyc >= 0) check("latency", 32'(cyc), 32'(mon_e.cyc));
            end
            if (last_fall >= 0) check("gap_ge_19", 32'((cyc - last_fall) >= 19), 32'd1);
        end
        if (fw_grant == 4'b0 && prev_grant != 4'b0) last_fall = cyc;
        prev_grant = fw_grant;
    end

    initial begin
        int t0;
        // Reset state
        tick(3);
        check("rst_grant", 32'(fw_grant), 32'd0);
        check("rst_id", 32'(fw_dev_id_enable), 32'd0);
        check("rst_busy", 32'(arb_busy), 32'd0);
        check("rst_cnt", 32'(grant_cnt), 32'd0);
        check("rst_flag", 32'(timeout_flag), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single request: grant 10 edges after first sampling
        fw_req = 4'b0010;
        expect_grant(4'b0010, cyc + 11);
        tick(1);
        check("busy_e0", 32'(arb_busy), 32'd0);
        tick(1);
        check("busy_e0p1", 32'(arb_busy), 32'd1);
        wait_grant("single");
        tick(5);
        fw_req = 4'b0;
        wait_idle("single");

        // Round robin with all four requesting
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_cnt = 0;
        fw_req = 4'b1111;
        expect_grant(4'b0001, -1);
        expect_grant(4'b0010, -1);
        expect_grant(4'b0100, -1);
        expect_grant(4'b1000, -1);
        expect_grant(4'b0001, -1);
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr");
            tick(5);
            fw_req = fw_req & ~fw_grant;
            tick(1);
            fw_req = (k < 4) ? 4'b1111 : 4'b0000;
        end
        wait_idle("rr");

        // Software lock blocks new grants only
        sw_lock = 1'b1;
        fw_req = 4'b0100;
        tick(50);
        check("lock_busy", 32'(arb_busy), 32'd0);
        check("lock_grant", 32'(fw_grant), 32'd0);
        sw_lock = 1'b0;
        expect_grant(4'b0100, cyc + 11);
        wait_grant("unlock");
        sw_lock = 1'b1;
        tick(5);
        check("lock_in_grant", 32'(fw_grant), 32'b0100);
        fw_req = 4'b0;
        tick(1);
        sw_lock = 1'b0;
        wait_idle("lock");

        // Request dropped during GUARD_IN: no grant, rr_ptr untouched (stays at 3)
        fw_req = 4'b1000;
        tick(4);
        fw_req = 4'b0;
        tick(20);
        check("abort_busy", 32'(arb_busy), 32'd0);
        check("abort_cnt", 32'(grant_cnt), 32'(exp_cnt));
        fw_req = 4'b1001;
        expect_grant(4'b1000, cyc + 11);
        wait_grant("abort_rr");
        tick(3);
        fw_req = 4'b0;
        wait_idle("abort_rr");

`ifdef COM_FW_DUT_ARBITER_TIMEOUT_EN
        // Watchdog forced release and rearm
        fw_req = 4'b0001;
        expect_grant(4'b0001, cyc + 11);
        wait_grant("wd");
        t0 = cyc;
        for (int i = 0; i < 100 && fw_grant != 4'b0; i++) @(negedge iob_clk);
        check("wd_len", 32'(cyc - t0), 32'd20);
        check("wd_flag", 32'(timeout_flag), 32'b0001);
        tick(40);
        fw_req = 4'b0;
        tick(1);
        fw_req = 4'b0001;
        expect_grant(4'b0001, cyc + 11);
        wait_grant("wd_rearm");
        fw_req = 4'b0;
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        check("wd_clr", 32'(timeout_flag), 32'd0);
        wait_idle("wd");
`else
        t0 = cyc;
        timeout_clr = 1'b1;
        tick(1);
        timeout_clr = 1'b0;
        check("flag_tied", 32'(timeout_flag), 32'd0);
`endif

        // Reset in the middle of a grant
        fw_req = 4'b0001;
        expect_grant(4'b0001, cyc + 11);
        wait_grant("midrst");
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_grant", 32'(fw_grant), 32'd0);
        check("midrst_id", 32'(fw_dev_id_enable), 32'd0);
        check("midrst_cnt", 32'(grant_cnt), 32'd0);
        check("midrst_busy", 32'(arb_busy), 32'd0);
        reset = 1'b0;
        fw_req = 4'b0;
        tick(3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
